rcc_char_reader: RTL and testbench
==================================

RCC_CHAR_READER -- requirements
Module: rcc_char_reader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning character FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have port rcc_clk  input  1  single clock; all state samples on posedge rcc_clk.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port enable  input  1  load strobe of the upstream character holding register; high for one or more cycles per load.
REQ-005 The block SHALL have port din  input  8  holding-register output (the converted DTMF character).
REQ-006 The block SHALL have port rd_ready  input  1  host accepts the presented character.
REQ-007 The block SHALL have port clr_ovf  input  1  synchronous clear of the sticky overflow flag.
REQ-008 The block SHALL have port dout  output  8  presented character.
REQ-009 The block SHALL have port dout_valid  output  1  dout holds an undelivered character.
REQ-010 The block SHALL have port count  output  log2(DEPTH)+1  number of stored characters, including the presented one.
REQ-011 The block SHALL have port ovf  output  1  sticky flag set when a character was dropped.

Function
REQ-012 Capture SHALL occur on the falling edge of enable, detected as enable_q=1 and enable=0 at posedge. This gives exactly one capture per load, however long the strobe lasts. din SHALL be sampled in that same cycle.
REQ-013 A captured character SHALL be written to the FIFO tail. When the FIFO holds DEPTH entries, the character SHALL be discarded and ovf SHALL be set the next cycle. FIFO contents SHALL be unchanged.
REQ-014 Output FSM states: EMPTY, PRESENT. EMPTY->PRESENT when count becomes nonzero. PRESENT->EMPTY on handshake (dout_valid and rd_ready) when no other entry remains.
REQ-015 Latency: a character captured into an empty FIFO SHALL appear on dout with dout_valid=1 one cycle after the capture cycle.
REQ-016 dout SHALL be registered from the FIFO head. dout and dout_valid SHALL stay stable while dout_valid=1 and rd_ready=0.
REQ-017 On handshake with more entries queued, the next character SHALL be presented the following cycle, with dout_valid remaining 1. Sustained throughput SHALL be one character per cycle.
REQ-018 Simultaneous capture and handshake SHALL be accepted even when count=DEPTH. Pop takes precedence in the full check, so there is no overflow and count is unchanged.
REQ-019 Pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH. count SHALL never exceed DEPTH or go below 0.
REQ-020 rd_ready while dout_valid=0 SHALL have no effect.
REQ-021 clr_ovf SHALL clear ovf. If clr_ovf coincides with a dropping capture, ovf SHALL remain 1 (set wins).
REQ-022 The block SHALL never modify din-side state or drive enable (read-only consumer).

Reset
REQ-023 On reset assertion, asynchronously: dout=8'h00, dout_valid=0, count=0, ovf=0, FSM=EMPTY, pointers=0, enable_q=0.
REQ-024 Reset mid-transfer SHALL discard all queued characters. An enable falling edge in the first cycle after reset release SHALL NOT be captured, because enable_q starts at 0.
REQ-025 FIFO storage array SHALL NOT require reset.

Structure
REQ-026 The FSM state encodings, DEPTH default, and the 8'h00 idle character SHALL live in the shared results_conv header/package.
REQ-027 FIFO storage and pointers SHALL be a sub-module rcc_char_fifo. Edge detect, FSM, and output register SHALL be in the top level.

Verification
REQ-028 Single character: enable high 3 cycles with din=8'h35, then low -> dout=8'h35 and dout_valid=1 one cycle after the falling edge; rd_ready=1 -> dout_valid=0 next cycle, count=0.
REQ-029 Fill/overflow (DEPTH=4): five captures 8'h31..8'h35, rd_ready=0 -> count=4, ovf=1, dout=8'h31. Draining then yields 31,32,33,34 in order.
REQ-030 Full with simultaneous events: count=4, capture 8'h23 while handshaking -> ovf stays 0, count=4, 8'h23 emerges last.
REQ-031 Backpressure/throughput: 3 queued, rd_ready held 1 -> three consecutive cycles of dout_valid=1 with distinct characters, then EMPTY.
REQ-032 Reset mid-operation: count=2, assert reset asynchronously -> all outputs 0 immediately. Enable falling edge in the first post-reset cycle -> no capture.
REQ-033 clr_ovf: with ovf=1, pulse clr_ovf -> ovf=0. Pulse clr_ovf together with a dropping capture -> ovf=1.

Source files
------------

// File: rtl/results_conv_pkg.sv
// Shared definitions for the results-conversion character path.
//   out_state_e  : output presentation FSM encodings
//   DefaultDepth : default character FIFO depth
//   IdleChar     : value driven on dout when nothing has been presented
package results_conv_pkg;

  typedef enum logic {
    StEmpty   = 1'b0,
    StPresent = 1'b1
  } out_state_e;

  localparam int unsigned DefaultDepth = 4;
  localparam logic [7:0]  IdleChar     = 8'h00;

endpackage

// File: rtl/rcc_char_fifo.sv
// Character FIFO for rcc_char_reader. Storage, pointers and occupancy.
// Also provides a look-ahead of the next head character (bypassing the write
// data when the FIFO is about to go from empty to one entry) so the parent
// can register dout without an extra cycle of latency.
//   clk_i        : clock
//   reset_i      : asynchronous active-high reset (pointers/count only)
//   push_i       : write wdata_i at the tail (caller guarantees space)
//   pop_i        : drop the head entry (caller guarantees non-empty)
//   wdata_i      : character to write
//   count_o      : current occupancy
//   full_o       : occupancy equals DEPTH
//   count_next_o : occupancy after this cycle's push/pop
//   head_next_o  : head character after this cycle's push/pop
module rcc_char_fifo #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [7:0]    wdata_i,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic [CW-1:0] count_next_o,
  output logic [7:0]    head_next_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW-1:0] rd_ptr_next;
  logic [CW-1:0] count_q, count_after_pop;

  // Storage is never reset; only entries covered by count are ever read.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_next_o;
    end
  end

  always_comb begin
    count_next_o    = count_q + CW'(push_i) - CW'(pop_i);
    count_after_pop = count_q - CW'(pop_i);
    rd_ptr_next     = rd_ptr_q + AW'(pop_i);
    // If nothing survives the pop, the only possible new head is the write data.
    if (count_after_pop == '0) begin
      head_next_o = wdata_i;
    end else begin
      head_next_o = mem_q[rd_ptr_next];
    end
  end

  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/rcc_char_reader.sv
// Reads converted DTMF characters from an upstream holding register and
// presents them to a host through a valid/ready style interface.
// One character is captured per falling edge of the load strobe, queued in a
// small FIFO, and presented on a registered output.
//   rcc_clk    : clock
//   reset      : asynchronous active-high reset
//   enable     : holding-register load strobe (capture on its falling edge)
//   din        : holding-register character
//   rd_ready   : host accepts the presented character
//   clr_ovf    : clear the sticky overflow flag
//   dout       : presented character
//   dout_valid : dout holds an undelivered character
//   count      : stored characters, including the presented one
//   ovf        : sticky flag, a character was dropped because the FIFO was full
module rcc_char_reader
  import results_conv_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth
) (
  input  logic                     rcc_clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [7:0]               din,
  input  logic                     rd_ready,
  input  logic                     clr_ovf,
  output logic [7:0]               dout,
  output logic                     dout_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  out_state_e    state_q, state_d;
  logic          enable_q;
  logic [7:0]    dout_q, dout_d;
  logic          ovf_q, ovf_d;
  logic          capture, pop, push, drop, full;
  logic [CW-1:0] count_next;
  logic [7:0]    head_next;

  assign capture = enable_q & ~enable;
  assign pop     = (state_q == StPresent) & rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push    = capture & (~full | pop);
  assign drop    = capture & full & ~pop;

  rcc_char_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i        (rcc_clk),
    .reset_i      (reset),
    .push_i       (push),
    .pop_i        (pop),
    .wdata_i      (din),
    .count_o      (count),
    .full_o       (full),
    .count_next_o (count_next),
    .head_next_o  (head_next)
  );

  always_ff @(posedge rcc_clk or posedge reset) begin
    if (reset) begin
      enable_q <= 1'b0;
      state_q  <= StEmpty;
      dout_q   <= IdleChar;
      ovf_q    <= 1'b0;
    end else begin
      enable_q <= enable;
      state_q  <= state_d;
      dout_q   <= dout_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    if (count_next != '0) begin
      state_d = StPresent;
      // Reload only when nothing is presented or the host took the current one,
      // keeping dout stable under backpressure.
      if ((state_q == StEmpty) || pop) begin
        dout_d = head_next;
      end
    end else begin
      state_d = StEmpty;
      if (pop) dout_d = IdleChar;
    end
  end

  // Set wins over clear.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  assign dout       = dout_q;
  assign dout_valid = (state_q == StPresent);
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_rcc_char_reader.sv
module tb_rcc_char_reader;

  localparam int unsigned DEPTH = 4;

  logic       rcc_clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] din;
  logic       rd_ready;
  logic       clr_ovf;
  logic [7:0] dout;
  logic       dout_valid;
  logic [2:0] count;
  logic       ovf;

  int checks   = 0;
  int failures = 0;

  logic [7:0] sb_q [$];

  typedef struct {
    logic       en;
    logic [7:0] din;
    logic       rdy;
    logic       clr;
    logic       sb;      // character expected to be accepted into the FIFO
    logic       exp_valid;
    logic [7:0] exp_dout;
    int         exp_count;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs [$];

  rcc_char_reader #(
    .DEPTH (DEPTH)
  ) dut (
    .rcc_clk    (rcc_clk),
    .reset      (reset),
    .enable     (enable),
    .din        (din),
    .rd_ready   (rd_ready),
    .clr_ovf    (clr_ovf),
    .dout       (dout),
    .dout_valid (dout_valid),
    .count      (count),
    .ovf        (ovf)
  );

  always #5 rcc_clk = ~rcc_clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t v(input logic en, input logic [7:0] d, input logic rdy,
                             input logic clr, input logic sb, input logic ev,
                             input logic [7:0] ed, input int ec, input logic eo);
    vec_t r;
    r.en = en; r.din = d; r.rdy = rdy; r.clr = clr; r.sb = sb;
    r.exp_valid = ev; r.exp_dout = ed; r.exp_count = ec; r.exp_ovf = eo;
    return r;
  endfunction

  // Scoreboard: every handshake must deliver the oldest accepted character.
  always @(negedge rcc_clk) begin
    if (!reset && dout_valid && rd_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got %0h expected no delivery", dout);
      end else begin
        check("sb_dout", int'(dout), int'(sb_q.pop_front()));
      end
    end
  end

  // Called at posedge+1: drive one row, advance one edge, compare.
  task automatic apply(input vec_t r, input int idx);
    enable   = r.en;
    din      = r.din;
    rd_ready = r.rdy;
    clr_ovf  = r.clr;
    if (r.sb) sb_q.push_back(r.din);
    @(posedge rcc_clk);
    #1;
    check($sformatf("row%0d_valid", idx), int'(dout_valid), int'(r.exp_valid));
    check($sformatf("row%0d_count", idx), int'(count), r.exp_count);
    check($sformatf("row%0d_ovf", idx), int'(ovf), int'(r.exp_ovf));
    if (r.exp_valid) check($sformatf("row%0d_dout", idx), int'(dout), int'(r.exp_dout));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; din = 8'h00; rd_ready = 1'b0; clr_ovf = 1'b0;
    #1;
    check("rst_dout", int'(dout), 0);
    check("rst_valid", int'(dout_valid), 0);
    check("rst_count", int'(count), 0);
    check("rst_ovf", int'(ovf), 0);
    @(posedge rcc_clk);
    @(posedge rcc_clk);
    #1;
    reset = 1'b0;

    //              en din   rdy clr sb  | val dout  cnt ovf
    // single character
    vecs.push_back(v(1, 8'h35, 0, 0, 0,   0, 8'h00, 0, 0));
    vecs.push_back(v(1, 8'h35, 0, 0, 0,   0, 8'h00, 0, 0));
    vecs.push_back(v(1, 8'h35, 0, 0, 0,   0, 8'h00, 0, 0));
    vecs.push_back(v(0, 8'h35, 0, 0, 1,   1, 8'h35, 1, 0));
    vecs.push_back(v(0, 8'h35, 1, 0, 0,   0, 8'h00, 0, 0));
    vecs.push_back(v(0, 8'h00, 1, 0, 0,   0, 8'h00, 0, 0));
    // fill to DEPTH, then overflow
    vecs.push_back(v(1, 8'h31, 0, 0, 0,   0, 8'h00, 0, 0));
    vecs.push_back(v(0, 8'h31, 0, 0, 1,   1, 8'h31, 1, 0));
    vecs.push_back(v(1, 8'h32, 0, 0, 0,   1, 8'h31, 1, 0));
    vecs.push_back(v(0, 8'h32, 0, 0, 1,   1, 8'h31, 2, 0));
    vecs.push_back(v(1, 8'h33, 0, 0, 0,   1, 8'h31, 2, 0));
    vecs.push_back(v(0, 8'h33, 0, 0, 1,   1, 8'h31, 3, 0));
    vecs.push_back(v(1, 8'h34, 0, 0, 0,   1, 8'h31, 3, 0));
    vecs.push_back(v(0, 8'h34, 0, 0, 1,   1, 8'h31, 4, 0));
    vecs.push_back(v(1, 8'h35, 0, 0, 0,   1, 8'h31, 4, 0));
    vecs.push_back(v(0, 8'h35, 0, 0, 0,   1, 8'h31, 4, 1));
    // clear, then clear colliding with a dropping capture
    vecs.push_back(v(0, 8'h00, 0, 1, 0,   1, 8'h31, 4, 0));
    vecs.push_back(v(1, 8'h36, 0, 0, 0,   1, 8'h31, 4, 0));
    vecs.push_back(v(0, 8'h36, 0, 1, 0,   1, 8'h31, 4, 1));
    vecs.push_back(v(0, 8'h00, 0, 1, 0,   1, 8'h31, 4, 0));
    // full: capture together with handshake, then drain back to back
    vecs.push_back(v(1, 8'h23, 0, 0, 0,   1, 8'h31, 4, 0));
    vecs.push_back(v(0, 8'h23, 1, 0, 1,   1, 8'h32, 4, 0));
    vecs.push_back(v(0, 8'h00, 1, 0, 0,   1, 8'h33, 3, 0));
    vecs.push_back(v(0, 8'h00, 1, 0, 0,   1, 8'h34, 2, 0));
    vecs.push_back(v(0, 8'h00, 1, 0, 0,   1, 8'h23, 1, 0));
    vecs.push_back(v(0, 8'h00, 1, 0, 0,   0, 8'h00, 0, 0));
    // two queued characters ahead of the reset test
    vecs.push_back(v(1, 8'h41, 0, 0, 0,   0, 8'h00, 0, 0));
    vecs.push_back(v(0, 8'h41, 0, 0, 1,   1, 8'h41, 1, 0));
    vecs.push_back(v(1, 8'h42, 0, 0, 0,   1, 8'h41, 1, 0));
    vecs.push_back(v(0, 8'h42, 0, 0, 1,   1, 8'h41, 2, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end

    // Asynchronous reset mid-cycle with enable held high across it.
    enable = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    sb_q.delete();
    check("arst_dout", int'(dout), 0);
    check("arst_valid", int'(dout_valid), 0);
    check("arst_count", int'(count), 0);
    check("arst_ovf", int'(ovf), 0);
    @(posedge rcc_clk);
    #1;
    reset  = 1'b0;
    enable = 1'b0;   // falls in the first post-reset cycle
    @(posedge rcc_clk);
    #1;
    check("post_rst_count", int'(count), 0);
    check("post_rst_valid", int'(dout_valid), 0);

    apply(v(1, 8'h55, 0, 0, 0, 0, 8'h00, 0, 0), 100);
    apply(v(0, 8'h55, 0, 0, 1, 1, 8'h55, 1, 0), 101);
    apply(v(0, 8'h00, 0, 0, 0, 1, 8'h55, 1, 0), 102);
    apply(v(0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0), 103);

    check("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
